// File: rtl/dividor_bcd_fmt.sv
// Divider readout formatter: converts integer quotient and binary fraction
// into packed BCD (double dabble for integer, multiply-by-10 for fraction).
module dividor_bcd_fmt #(
    parameter int SIZE        = 4,
    parameter int FRAC_W      = 10,
    parameter int INT_DIGITS  = 2,
    parameter int FRAC_DIGITS = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [SIZE-1:0]          m,
    input  logic [FRAC_W-1:0]        f,
    output logic [4*INT_DIGITS-1:0]  int_bcd,
    output logic [4*FRAC_DIGITS-1:0] frac_bcd,
    output logic                     busy,
    output logic                     done
);

    localparam int IW   = 4 * INT_DIGITS;
    localparam int FW   = 4 * FRAC_DIGITS;
    localparam int PW   = FRAC_W + 4;
    localparam int CMAX = (SIZE > FRAC_DIGITS) ? SIZE : FRAC_DIGITS;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        INT,
        FRAC
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [SIZE-1:0] r_bin, w_bin_nxt;
    logic [IW-1:0]   r_iscr, w_iscr_nxt;
    logic [FRAC_W-1:0] r_acc, w_acc_nxt;
    logic [FW-1:0]   r_fscr, w_fscr_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [IW-1:0]   r_int_bcd, w_int_bcd_nxt;
    logic [FW-1:0]   r_frac_bcd, w_frac_bcd_nxt;
    logic            r_done, w_done_nxt;

    logic [IW-1:0]      w_adj;
    logic [IW+SIZE-1:0] w_cat;
    logic [PW-1:0]      w_prod;
    logic [3:0]         w_digit;
    logic [FW-1:0]      w_fshift;

    // Double-dabble correction: bias every nibble >=5 before the shift
    always_comb begin
        w_adj = '0;
        for (int i = 0; i < INT_DIGITS; i++) begin
            if (r_iscr[4*i +: 4] >= 4'd5)
                w_adj[4*i +: 4] = r_iscr[4*i +: 4] + 4'd3;
            else
                w_adj[4*i +: 4] = r_iscr[4*i +: 4];
        end
    end

    assign w_cat    = {w_adj, r_bin} << 1;
    assign w_prod   = {4'b0000, r_acc} * PW'(10);
    assign w_digit  = w_prod[PW-1:FRAC_W];
    assign w_fshift = (r_fscr << 4) | FW'(w_digit);

    always_comb begin
        w_state_nxt    = r_state;
        w_bin_nxt      = r_bin;
        w_iscr_nxt     = r_iscr;
        w_acc_nxt      = r_acc;
        w_fscr_nxt     = r_fscr;
        w_cnt_nxt      = r_cnt;
        w_int_bcd_nxt  = r_int_bcd;
        w_frac_bcd_nxt = r_frac_bcd;
        w_done_nxt     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_bin_nxt   = m;
                    w_acc_nxt   = f;
                    w_iscr_nxt  = '0;
                    w_fscr_nxt  = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = INT;
                end
            end
            INT: begin
                w_iscr_nxt = w_cat[IW+SIZE-1:SIZE];
                w_bin_nxt  = w_cat[SIZE-1:0];
                if (r_cnt == CW'(SIZE - 1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = FRAC;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            FRAC: begin
                w_acc_nxt  = w_prod[FRAC_W-1:0];
                w_fscr_nxt = w_fshift;
                if (r_cnt == CW'(FRAC_DIGITS - 1)) begin
                    w_cnt_nxt      = '0;
                    w_int_bcd_nxt  = r_iscr;
                    w_frac_bcd_nxt = w_fshift;
                    w_done_nxt     = 1'b1;
                    w_state_nxt    = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_bin      <= '0;
            r_iscr     <= '0;
            r_acc      <= '0;
            r_fscr     <= '0;
            r_cnt      <= '0;
            r_int_bcd  <= '0;
            r_frac_bcd <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bin      <= w_bin_nxt;
            r_iscr     <= w_iscr_nxt;
            r_acc      <= w_acc_nxt;
            r_fscr     <= w_fscr_nxt;
            r_cnt      <= w_cnt_nxt;
            r_int_bcd  <= w_int_bcd_nxt;
            r_frac_bcd <= w_frac_bcd_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign int_bcd  = r_int_bcd;
    assign frac_bcd = r_frac_bcd;
    assign busy     = (r_state != IDLE);
    assign done     = r_done;

endmodule

// File: tb/tb_dividor_bcd_fmt.sv
// Bench for dividor_bcd_fmt: directed boundaries plus random operands
// checked against a decimal arithmetic model.
module tb_dividor_bcd_fmt;

    localparam int SIZE        = 4;
    localparam int FRAC_W      = 10;
    localparam int INT_DIGITS  = 2;
    localparam int FRAC_DIGITS = 3;
    localparam int IW          = 4 * INT_DIGITS;
    localparam int FW          = 4 * FRAC_DIGITS;
    localparam int LAT         = SIZE + FRAC_DIGITS;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [SIZE-1:0]   m;
    logic [FRAC_W-1:0] f;
    logic [IW-1:0]     int_bcd;
    logic [FW-1:0]     frac_bcd;
    logic              busy;
    logic              done;

    int total = 0;
    int bad   = 0;

    dividor_bcd_fmt #(
        .SIZE(SIZE), .FRAC_W(FRAC_W),
        .INT_DIGITS(INT_DIGITS), .FRAC_DIGITS(FRAC_DIGITS)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .m(m), .f(f),
        .int_bcd(int_bcd), .frac_bcd(frac_bcd),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] ref_int(input int mv);
        logic [IW-1:0] r;
        int v;
        r = '0;
        v = mv;
        for (int i = 0; i < INT_DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Truncated decimal fraction: floor(f * 10^D / 2^FRAC_W)
    function automatic logic [FW-1:0] ref_frac(input int fv);
        logic [FW-1:0] r;
        longint v;
        r = '0;
        v = (longint'(fv) * (10 ** FRAC_DIGITS)) >> FRAC_W;
        for (int i = 0; i < FRAC_DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic launch(input int mi, input int fi);
        @(negedge clk);
        m     = SIZE'(mi);
        f     = FRAC_W'(fi);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        start = 1'b0;
        m     = '0;
        f     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (int_bcd !== 8'h00) begin
            bad++;
            $display("FAIL reset_int got=%h want=00", int_bcd);
        end
        total++;
        if (frac_bcd !== 12'h000) begin
            bad++;
            $display("FAIL reset_frac got=%h want=000", frac_bcd);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_busy got=%b want=0", busy);
        end
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL reset_done got=%b want=0", done);
        end
    endtask

    task automatic test_conv(input int mi, input int fi, input string nm);
        int c;
        logic [IW-1:0] ei;
        logic [FW-1:0] ef;
        ei = ref_int(mi);
        ef = ref_frac(fi);
        launch(mi, fi);
        wait_done(c);
        total++;
        if (c != LAT) begin
            bad++;
            $display("FAIL %s latency got=%0d want=%0d", nm, c, LAT);
        end
        total++;
        if (int_bcd !== ei || frac_bcd !== ef) begin
            bad++;
            $display("FAIL %s m=%0d f=%0d got=%h.%h want=%h.%h",
                     nm, mi, fi, int_bcd, frac_bcd, ei, ef);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s busy_at_done got=%b want=0", nm, busy);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL %s done_width got=%b want=0", nm, done);
        end
    endtask

    task automatic test_directed;
        test_conv(0, 341, "third");
        test_conv(3, 341, "ten_thirds");
        test_conv(3, 0, "three");
        test_conv(15, 1023, "max");
        test_conv(0, 512, "half");
        test_conv(0, 1, "lsb");
    endtask

    task automatic test_random;
        for (int i = 0; i < 30; i++)
            test_conv(int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 1023)), "random");
    endtask

    task automatic test_ignore_busy;
        int pulses = 0;
        int dcyc = -1;
        int busy_low = 0;
        logic [IW-1:0] gi = '0;
        logic [FW-1:0] gf = '0;
        launch(5, 100);
        for (int c = 1; c <= 20; c++) begin
            if (c == 2 || c == 4) begin
                m     = 4'd12;
                f     = 10'd900;
                start = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
            if (c < LAT && busy !== 1'b1) busy_low++;
            if (done === 1'b1) begin
                pulses++;
                dcyc = c;
                gi   = int_bcd;
                gf   = frac_bcd;
            end
        end
        total++;
        if (pulses != 1 || dcyc != LAT) begin
            bad++;
            $display("FAIL ignore_pulses got=%0d@%0d want=1@%0d",
                     pulses, dcyc, LAT);
        end
        total++;
        if (gi !== ref_int(5) || gf !== ref_frac(100)) begin
            bad++;
            $display("FAIL ignore_value got=%h.%h want=%h.%h",
                     gi, gf, ref_int(5), ref_frac(100));
        end
        total++;
        if (busy_low != 0) begin
            bad++;
            $display("FAIL ignore_busy low_cycles=%0d want=0", busy_low);
        end
    endtask

    task automatic test_back_to_back;
        int c;
        int held_bad = 0;
        logic [IW-1:0] pi;
        logic [FW-1:0] pf;
        launch(7, 600);
        wait_done(c);
        pi = int_bcd;
        pf = frac_bcd;
        total++;
        if (c != LAT || pi !== ref_int(7) || pf !== ref_frac(600)) begin
            bad++;
            $display("FAIL b2b_first got=%h.%h@%0d want=%h.%h@%0d",
                     pi, pf, c, ref_int(7), ref_frac(600), LAT);
        end
        m     = 4'd9;
        f     = 10'd768;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m     = 4'd2;
        f     = 10'd5;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_accept busy got=%b want=1", busy);
        end
        for (c = 1; c <= LAT; c++) begin
            @(negedge clk);
            if (c < LAT && (int_bcd !== pi || frac_bcd !== pf)) held_bad++;
        end
        total++;
        if (held_bad != 0) begin
            bad++;
            $display("FAIL b2b_hold changed_cycles=%0d want=0", held_bad);
        end
        total++;
        if (done !== 1'b1 || int_bcd !== 8'h09 || frac_bcd !== 12'h750) begin
            bad++;
            $display("FAIL b2b_second got=%b %h.%h want=1 09.750",
                     done, int_bcd, frac_bcd);
        end
    endtask

    task automatic test_reset_mid;
        int pulses = 0;
        launch(11, 777);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid busy/done got=%b/%b want=0/0", busy, done);
        end
        total++;
        if (int_bcd !== 8'h00 || frac_bcd !== 12'h000) begin
            bad++;
            $display("FAIL rst_mid_out got=%h.%h want=00.000",
                     int_bcd, frac_bcd);
        end
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        total++;
        if (pulses != 0 || int_bcd !== 8'h00) begin
            bad++;
            $display("FAIL rst_mid_abort pulses=%0d int=%h want=0 00",
                     pulses, int_bcd);
        end
        test_conv(6, 256, "after_rst");
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        m     = '0;
        f     = '0;
        test_reset();
        test_directed();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
